mem_arbiter: RTL and testbench

Shares the single-port 4 KiB × 8 system RAM between the CPU and the GPU. Each side keeps its own read and write request interfaces; the arbiter serialises them onto one RAM port, one transaction at a time. It uses round-robin between the two requesters. The GPU framebuffer clear/draw traffic (0x100–0x1FF) and CPU fetch/load/store traffic pass through here.

---
 rtl/mem_arbiter_if.sv | 53 +++++
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the CPU and GPU request ports and the shared RAM
// port of mem_arbiter. The slave modport is the arbiter's view; the master
// modport is the system side (the two requesters plus the RAM itself).
interface mem_arbiter_if;
    // CPU requester
    logic        cpu_mem_read;
    logic [11:0] cpu_mem_read_addr;
    logic [7:0]  cpu_mem_read_data;
    logic        cpu_mem_read_ack;
    logic        cpu_mem_write;
    logic [11:0] cpu_mem_write_addr;
    logic [7:0]  cpu_mem_write_data;
    logic        cpu_mem_write_ack;

    // GPU requester
    logic        gpu_mem_read;
    logic [11:0] gpu_mem_read_addr;
    logic [7:0]  gpu_mem_read_data;
    logic        gpu_mem_read_ack;
    logic        gpu_mem_write;
    logic [11:0] gpu_mem_write_addr;
    logic [7:0]  gpu_mem_write_data;
    logic        gpu_mem_write_ack;

    // Shared single-port RAM (synchronous read)
    logic        ram_en;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    modport slave (
        input  cpu_mem_read, cpu_mem_read_addr,
        input  cpu_mem_write, cpu_mem_write_addr, cpu_mem_write_data,
        output cpu_mem_read_data, cpu_mem_read_ack, cpu_mem_write_ack,
        input  gpu_mem_read, gpu_mem_read_addr,
        input  gpu_mem_write, gpu_mem_write_addr, gpu_mem_write_data,
        output gpu_mem_read_data, gpu_mem_read_ack, gpu_mem_write_ack,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output cpu_mem_read, cpu_mem_read_addr,
        output cpu_mem_write, cpu_mem_write_addr, cpu_mem_write_data,
        input  cpu_mem_read_data, cpu_mem_read_ack, cpu_mem_write_ack,
        output gpu_mem_read, gpu_mem_read_addr,
        output gpu_mem_write, gpu_mem_write_addr, gpu_mem_write_data,
        input  gpu_mem_read_data, gpu_mem_read_ack, gpu_mem_write_ack,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises CPU and GPU read/write requests onto the single
// 4 KiB x 8 RAM port. Round-robin between requesters, write before read
// within a requester, one transaction every four cycles:
// IDLE (arbitrate) -> ACCESS (RAM enabled) -> COMPLETE (capture) -> ACK.
module mem_arbiter (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_COMPLETE = 2'd2,
        ST_ACK      = 2'd3
    } state_t;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_GPU = 1'b1
    } owner_t;

    state_t      state;
    state_t      state_next;
    owner_t      owner;        // requester served by the current transaction
    owner_t      last_owner;   // winner of the most recent arbitration
    logic        op_write;     // current transaction is a write

    logic        cpu_pend;
    logic        gpu_pend;
    logic        any_pend;
    owner_t      win_owner;
    logic        win_write;
    logic [11:0] win_addr;
    logic [7:0]  win_wdata;

    // Arbitration: pick the requester (round-robin on ties), then write before read.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would otherwise infer a latch.
        cpu_pend  = bus.cpu_mem_read | bus.cpu_mem_write;
        gpu_pend  = bus.gpu_mem_read | bus.gpu_mem_write;
        any_pend  = cpu_pend | gpu_pend;
        win_owner = OWNER_GPU;
        win_write = 1'b0;
        win_addr  = '0;
        win_wdata = '0;

        if (cpu_pend && (!gpu_pend || last_owner == OWNER_GPU)) begin
            win_owner = OWNER_CPU;
        end

        if (win_owner == OWNER_CPU) begin
            win_write = bus.cpu_mem_write;
            win_addr  = bus.cpu_mem_write ? bus.cpu_mem_write_addr : bus.cpu_mem_read_addr;
            win_wdata = bus.cpu_mem_write_data;
        end else begin
            win_write = bus.gpu_mem_write;
            win_addr  = bus.gpu_mem_write ? bus.gpu_mem_write_addr : bus.gpu_mem_read_addr;
            win_wdata = bus.gpu_mem_write_data;
        end
    end

    // Next-state logic: only IDLE waits; every other state advances unconditionally,
    // so a request dropped mid-transaction still lets the FSM return to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (any_pend) state_next = ST_ACCESS;
            ST_ACCESS:   state_next = ST_COMPLETE;
            ST_COMPLETE: state_next = ST_ACK;
            ST_ACK:      state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the values from before the edge, independent of statement order.
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Transaction latch, RAM port drive, read-data capture and ack pulses.
    // ram_addr/ram_wdata double as the latched address/data and hold outside ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner                 <= OWNER_CPU;
            last_owner            <= OWNER_GPU;
            op_write              <= 1'b0;
            bus.ram_en            <= 1'b0;
            bus.ram_we            <= 1'b0;
            bus.ram_addr          <= '0;
            bus.ram_wdata         <= '0;
            bus.cpu_mem_read_data <= '0;
            bus.gpu_mem_read_data <= '0;
            bus.cpu_mem_read_ack  <= 1'b0;
            bus.cpu_mem_write_ack <= 1'b0;
            bus.gpu_mem_read_ack  <= 1'b0;
            bus.gpu_mem_write_ack <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_pend) begin
                        owner         <= win_owner;
                        last_owner    <= win_owner;
                        op_write      <= win_write;
                        bus.ram_en    <= 1'b1;
                        bus.ram_we    <= win_write;
                        bus.ram_addr  <= win_addr;
                        bus.ram_wdata <= win_wdata;
                    end
                end
                ST_ACCESS: begin
                    bus.ram_en <= 1'b0;
                    bus.ram_we <= 1'b0;
                end
                ST_COMPLETE: begin
                    if (owner == OWNER_CPU) begin
                        if (op_write) begin
                            bus.cpu_mem_write_ack <= 1'b1;
                        end else begin
                            bus.cpu_mem_read_data <= bus.ram_rdata;
                            bus.cpu_mem_read_ack  <= 1'b1;
                        end
                    end else begin
                        if (op_write) begin
                            bus.gpu_mem_write_ack <= 1'b1;
                        end else begin
                            bus.gpu_mem_read_data <= bus.ram_rdata;
                            bus.gpu_mem_read_ack  <= 1'b1;
                        end
                    end
                end
                ST_ACK: begin
                    bus.cpu_mem_read_ack  <= 1'b0;
                    bus.cpu_mem_write_ack <= 1'b0;
                    bus.gpu_mem_read_ack  <= 1'b0;
                    bus.gpu_mem_write_ack <= 1'b0;
                end
                default: begin
                    bus.ram_en <= 1'b0;
                    bus.ram_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// transaction-level reference model. The model knows only the externally
// visible rules: one grant per four cycles from an idle slot, round-robin on
// ties, write before read, RAM enabled one cycle after the grant, ack three
// cycles after it, writes visible to every later transaction.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Environment RAM: synchronous read, data valid the cycle after enable.
    logic [7:0] ram [4096];
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
            bus.ram_rdata <= ram[bus.ram_addr];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Requester state; op index = {gpu, write}: 0 cpu rd, 1 cpu wr, 2 gpu rd, 3 gpu wr.
    bit          act   [4];
    bit          just_dropped [4];
    logic [11:0] a_q   [4];
    logic [7:0]  d_q   [4];
    int          ack_k [4];
    bit          ack_owner_q [$];   // 0 = CPU, 1 = GPU, in ack order
    string       acktag [4] = '{"cpu_rd_ack", "cpu_wr_ack", "gpu_rd_ack", "gpu_wr_ack"};

    // Reference model state.
    logic [7:0]  ref_mem [4096];
    int          k;          // cycle index, advanced once per commit
    int          free_k;     // first cycle the arbiter may grant again
    bit          have_txn;
    int          g_k;
    int          g_idx;
    bit          g_gpu;
    bit          g_wr;
    logic [11:0] g_addr;
    logic [7:0]  g_wdata;
    logic [7:0]  g_rdata;
    bit          last_gpu;
    logic [7:0]  hold_rd [2];
    logic [11:0] exp_addr;

    function automatic logic ack_of(input int i);
        case (i)
            0:       return bus.cpu_mem_read_ack;
            1:       return bus.cpu_mem_write_ack;
            2:       return bus.gpu_mem_read_ack;
            default: return bus.gpu_mem_write_ack;
        endcase
    endfunction

    task automatic apply_drives();
        bus.cpu_mem_read       = act[0];
        bus.cpu_mem_read_addr  = a_q[0];
        bus.cpu_mem_write      = act[1];
        bus.cpu_mem_write_addr = a_q[1];
        bus.cpu_mem_write_data = d_q[1];
        bus.gpu_mem_read       = act[2];
        bus.gpu_mem_read_addr  = a_q[2];
        bus.gpu_mem_write      = act[3];
        bus.gpu_mem_write_addr = a_q[3];
        bus.gpu_mem_write_data = d_q[3];
    endtask

    task automatic model_reset();
        have_txn   = 1'b0;
        last_gpu   = 1'b1;
        hold_rd[0] = 8'h00;
        hold_rd[1] = 8'h00;
        exp_addr   = 12'h000;
        free_k     = 0;
    endtask

    task automatic raise(input int i, input logic [11:0] a, input logic [7:0] d);
        act[i] = 1'b1;
        a_q[i] = a;
        d_q[i] = d;
        apply_drives();
    endtask

    // Mid-cycle: compare DUT outputs with the model, then react to acks.
    task automatic sample();
        bit exp_en;
        @(negedge clk);
        if (have_txn && k == g_k + 1) exp_addr = g_addr;
        if (have_txn && k == g_k + 2 && g_wr) ref_mem[g_addr] = g_wdata;
        if (have_txn && k == g_k + 3 && !g_wr) hold_rd[g_gpu] = g_rdata;
        exp_en = have_txn && (k == g_k + 1);

        check("ram_en",   32'(bus.ram_en),   32'(exp_en));
        check("ram_we",   32'(bus.ram_we),   32'(exp_en && g_wr));
        check("ram_addr", 32'(bus.ram_addr), 32'(exp_addr));
        if (exp_en && g_wr) check("ram_wdata", 32'(bus.ram_wdata), 32'(g_wdata));
        for (int i = 0; i < 4; i++) begin
            check(acktag[i], 32'(ack_of(i)), 32'(have_txn && k == g_k + 3 && g_idx == i));
        end
        check("cpu_rd_data", 32'(bus.cpu_mem_read_data), 32'(hold_rd[0]));
        check("gpu_rd_data", 32'(bus.gpu_mem_read_data), 32'(hold_rd[1]));

        for (int i = 0; i < 4; i++) begin
            just_dropped[i] = 1'b0;
            if (ack_of(i)) begin
                act[i]          = 1'b0;
                just_dropped[i] = 1'b1;
                ack_k[i]        = k;
                ack_owner_q.push_back(i >= 2);
            end
        end
        apply_drives();
    endtask

    // Optionally raise new random requests, then let the model arbitrate this cycle.
    task automatic commit(input int raise_pct);
        bit cpu_p, gpu_p;
        for (int i = 0; i < 4; i++) begin
            if (!act[i] && !just_dropped[i] && $urandom_range(0, 99) < raise_pct) begin
                act[i] = 1'b1;
                a_q[i] = 12'h1F8 + 12'($urandom_range(0, 15));
                d_q[i] = 8'($urandom);
            end
        end
        apply_drives();

        if (have_txn && k > g_k + 3) have_txn = 1'b0;
        cpu_p = act[0] | act[1];
        gpu_p = act[2] | act[3];
        if (k >= free_k && (cpu_p || gpu_p)) begin
            g_gpu    = (cpu_p && gpu_p) ? !last_gpu : gpu_p;
            g_idx    = g_gpu ? 2 : 0;
            g_wr     = act[g_idx + 1];
            g_idx    = g_idx + (g_wr ? 1 : 0);
            g_addr   = a_q[g_idx];
            g_wdata  = d_q[g_idx];
            g_rdata  = ref_mem[g_addr];
            g_k      = k;
            have_txn = 1'b1;
            free_k   = k + 4;
            last_gpu = g_gpu;
        end
        k++;
    endtask

    task automatic run_quiet(input int max_cyc);
        bit done;
        done = 1'b0;
        for (int n = 0; n < max_cyc && !done; n++) begin
            sample();
            commit(0);
            done = !(act[0] | act[1] | act[2] | act[3]) && !have_txn;
        end
        check("quiet_timeout", 32'(done), 32'(1'b1));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) act[i] = 1'b0;
        apply_drives();
        model_reset();
        repeat (2) sample();
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r_k;
        int n_alt;

        for (int i = 0; i < 4096; i++) begin
            ram[i]     = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        ram[12'h200]     = 8'hA5;
        ref_mem[12'h200] = 8'hA5;
        k = 0;

        // Reset held with every request high: outputs stay at reset values.
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            act[i] = 1'b1;
            a_q[i] = 12'h1F8 + 12'(i);
            d_q[i] = 8'h10 + 8'(i);
            just_dropped[i] = 1'b0;
            ack_k[i] = -1;
        end
        apply_drives();
        model_reset();
        repeat (3) sample();
        check("rst_ram_wdata", 32'(bus.ram_wdata), 32'(8'h00));
        rst_n = 1'b1;
        ack_owner_q.delete();
        commit(0);
        run_quiet(40);
        check("first_grant_cpu", 32'(ack_owner_q[0]), 32'(1'b0));

        // CPU read of a preloaded location.
        sample(); raise(0, 12'h200, 8'h00); r_k = k; commit(0); run_quiet(20);
        check("cpu_rd_200_data", 32'(bus.cpu_mem_read_data), 32'(8'hA5));
        check("cpu_rd_200_lat", 32'(ack_k[0] - r_k), 32'(3));

        // GPU write then CPU read of the same address.
        sample(); raise(3, 12'h1FF, 8'h3C); r_k = k; commit(0); run_quiet(20);
        check("gpu_wr_1ff_lat", 32'(ack_k[3] - r_k), 32'(3));
        sample(); raise(0, 12'h1FF, 8'h00); commit(0); run_quiet(20);
        check("cpu_rd_1ff_data", 32'(bus.cpu_mem_read_data), 32'(8'h3C));

        // Contention right after reset: CPU wins the first tie.
        do_reset();
        sample();
        raise(0, 12'h000, 8'h00);
        raise(3, 12'h100, 8'h00);
        r_k = k; commit(0); run_quiet(30);
        check("tie_cpu_lat", 32'(ack_k[0] - r_k), 32'(3));
        check("tie_gpu_lat", 32'(ack_k[3] - r_k), 32'(7));

        // Continuous requests from both sides: grants alternate.
        ack_owner_q.delete();
        repeat (48) begin sample(); commit(100); end
        n_alt = ack_owner_q.size();
        check("alt_count_ge6", 32'(n_alt >= 6), 32'(1'b1));
        for (int i = 1; i < n_alt; i++) begin
            check("alternate", 32'(ack_owner_q[i]), 32'(!ack_owner_q[i-1]));
        end
        run_quiet(60);

        // Same requester write and read together: write first, read sees it.
        sample();
        raise(3, 12'h150, 8'h81);
        raise(2, 12'h150, 8'h00);
        r_k = k; commit(0); run_quiet(30);
        check("gpu_wr_first", 32'(ack_k[3] - r_k), 32'(3));
        check("gpu_rd_after", 32'(ack_k[2] - r_k), 32'(7));
        check("gpu_rd_150", 32'(bus.gpu_mem_read_data), 32'(8'h81));

        // Reset asserted during ACCESS of a CPU write.
        sample(); raise(1, 12'h300, 8'hFF); commit(0);
        sample();                       // ACCESS cycle, ram_en checked high
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_ram_en", 32'(bus.ram_en), 32'(1'b0));
        check("rst_async_ram_we", 32'(bus.ram_we), 32'(1'b0));
        check("rst_async_ram_addr", 32'(bus.ram_addr), 32'(12'h000));
        for (int i = 0; i < 4; i++) act[i] = 1'b0;
        apply_drives();
        model_reset();
        repeat (4) sample();
        check("rst_ram_300_kept", 32'(ram[12'h300]), 32'(ref_mem[12'h300]));
        rst_n = 1'b1;
        sample(); raise(1, 12'h300, 8'hFF); commit(0); run_quiet(20);
        check("reissue_ram_300", 32'(ram[12'h300]), 32'(8'hFF));

        // Randomized traffic against the model.
        repeat (1500) begin sample(); commit(30); end
        run_quiet(80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
